// File: rtl/btb_update_issuer_pkg.sv
// Shared BTB update types and PC/target encoders, so the issuer packs index,
// tag and target exactly as the BTB read side unpacks them.
// Contents: geometry localparams, BTBUpdateEntry, ToBTB_Index/Tag/Addr helpers.
package btb_update_issuer_pkg;

  localparam int BTB_ISSUE_WIDTH  = 2;
  localparam int BTB_UPDATE_DEPTH = 8;
  localparam int BTB_INDEX_BITS   = 9;
  localparam int BTB_TAG_BITS     = 7;
  localparam int BTB_ADDR_BITS    = 13;
  localparam int BTB_FLAG_BITS    = 3;

  typedef struct packed {
    logic                      valid;
    logic [BTB_INDEX_BITS-1:0] index;
    logic [BTB_TAG_BITS-1:0]   tag;
    logic [BTB_ADDR_BITS-1:0]  data;
    logic [BTB_FLAG_BITS-1:0]  flags;  // {isCondBr, isRASPushBr, isRASPopBr}
  } BTBUpdateEntry;

  // index = PC[INDEX_BITS+1:2]
  function automatic logic [BTB_INDEX_BITS-1:0] ToBTB_Index(input logic [31:0] pc);
    return BTB_INDEX_BITS'(pc >> 2);
  endfunction

  // tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
  function automatic logic [BTB_TAG_BITS-1:0] ToBTB_Tag(input logic [31:0] pc);
    return BTB_TAG_BITS'(pc >> (BTB_INDEX_BITS + 2));
  endfunction

  // stored target = nextAddr[ADDR_BITS+1:2]
  function automatic logic [BTB_ADDR_BITS-1:0] ToBTB_Addr(input logic [31:0] addr);
    return BTB_ADDR_BITS'(addr >> 2);
  endfunction

endpackage

// File: rtl/btb_update_issuer_ptr.sv
// Circular head/tail pointer pair for the update buffer: up to DEPTH pushes and
// one pop per cycle, flush returns everything to zero.
// Ports: push_cnt/pop/flush in; head, tail, occupancy out (all registered).
module btb_update_issuer_ptr #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             pop,
  input  logic [OCC_W-1:0] push_cnt,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [OCC_W-1:0] occupancy
);

  // DEPTH is a power of two, so plain truncating adds wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      head      <= head + PTR_W'(pop);
      tail      <= tail + PTR_W'(push_cnt);
      occupancy <= occupancy + push_cnt - OCC_W'(pop);
    end
  end

endmodule

// File: rtl/btb_update_issuer.sv
// Filters resolved branches, coalesces updates to the same BTB entry and drains
// them one per cycle to the BTB write port (valid/ready, wr* from head storage).
// Ports: br* lanes + flush in; wrValid/wrIndex/wrTag/wrData/wrFlags out with
// wrReady in; dropCount (saturating overflow losses) and occupancy out.
module btb_update_issuer
  import btb_update_issuer_pkg::*;
#(
  parameter int ISSUE_WIDTH = BTB_ISSUE_WIDTH,
  parameter int DEPTH       = BTB_UPDATE_DEPTH,
  localparam int INDEX_BITS = BTB_INDEX_BITS,
  localparam int TAG_BITS   = BTB_TAG_BITS,
  localparam int ADDR_BITS  = BTB_ADDR_BITS,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int OCC_W      = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [ISSUE_WIDTH-1:0] brValid,
  input  logic [ISSUE_WIDTH-1:0] brTaken,
  input  logic [ISSUE_WIDTH-1:0] brIsAp,
  input  logic [31:0]            brAddr     [ISSUE_WIDTH],
  input  logic [31:0]            brNextAddr [ISSUE_WIDTH],
  input  logic [2:0]             brFlags    [ISSUE_WIDTH],
  output logic                   wrValid,
  input  logic                   wrReady,
  output logic [INDEX_BITS-1:0]  wrIndex,
  output logic [TAG_BITS-1:0]    wrTag,
  output logic [ADDR_BITS-1:0]   wrData,
  output logic [2:0]             wrFlags,
  output logic [15:0]            dropCount,
  output logic [OCC_W-1:0]       occupancy
);

  BTBUpdateEntry entry_q [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic             pop;

  logic [ISSUE_WIDTH-1:0] acc, is_rep, need, grant;
  logic [INDEX_BITS-1:0]  lane_idx  [ISSUE_WIDTH];
  logic [TAG_BITS-1:0]    lane_tag  [ISSUE_WIDTH];
  logic [ADDR_BITS-1:0]   win_data  [ISSUE_WIDTH];
  logic [2:0]             win_flags [ISSUE_WIDTH];
  logic [DEPTH-1:0]       hit       [ISSUE_WIDTH];
  logic [OCC_W-1:0]       rank      [ISSUE_WIDTH];
  logic [OCC_W-1:0]       free_slots, need_cnt, push_cnt, drop_cnt;
  logic [16:0]            drop_sum;

  // Output side reads only registered head storage: no wrReady -> wr* path.
  assign wrValid = entry_q[head].valid;
  assign pop     = wrValid & wrReady;
  assign wrIndex = wrValid ? entry_q[head].index : '0;
  assign wrTag   = wrValid ? entry_q[head].tag   : '0;
  assign wrData  = wrValid ? entry_q[head].data  : '0;
  assign wrFlags = wrValid ? entry_q[head].flags : '0;

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      acc[i]      = brValid[i] & brTaken[i] & ~brIsAp[i];
      lane_idx[i] = ToBTB_Index(brAddr[i]);
      lane_tag[i] = ToBTB_Tag(brAddr[i]);
    end
  end

  // Lanes sharing a key collapse onto the lowest such lane, carrying the
  // highest such lane's payload (ascending scan: last match wins).
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      is_rep[i]    = acc[i];
      win_data[i]  = ToBTB_Addr(brNextAddr[i]);
      win_flags[i] = brFlags[i];
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        if (acc[j] && lane_idx[j] == lane_idx[i] && lane_tag[j] == lane_tag[i]) begin
          if (j < i) is_rep[i] = 1'b0;
          if (j > i) begin
            win_data[i]  = ToBTB_Addr(brNextAddr[j]);
            win_flags[i] = brFlags[j];
          end
        end
      end
    end
  end

  // Buffer match: the head leaving this cycle is excluded so a late update to
  // the same entry is not lost with it; it takes a fresh slot instead.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      for (int d = 0; d < DEPTH; d++) begin
        hit[i][d] = is_rep[i] && entry_q[d].valid &&
                    entry_q[d].index == lane_idx[i] &&
                    entry_q[d].tag == lane_tag[i] &&
                    !(pop && head == PTR_W'(d));
      end
      need[i] = is_rep[i] && (hit[i] == '0);
    end
  end

  // In-order tail allocation; lanes past the free-slot count are dropped.
  always_comb begin
    free_slots = OCC_W'(DEPTH) - occupancy + OCC_W'(pop);
    need_cnt   = '0;
    push_cnt   = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      rank[i]  = need_cnt;
      grant[i] = need[i] && (need_cnt < free_slots);
      if (need[i])  need_cnt = need_cnt + OCC_W'(1);
      if (grant[i]) push_cnt = push_cnt + OCC_W'(1);
    end
    drop_cnt = need_cnt - push_cnt;
    drop_sum = {1'b0, dropCount} + 17'(drop_cnt);
  end

  // Later nonblocking writes win: a slot freed by this cycle's pop can be
  // refilled in the same cycle when the buffer was full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DEPTH; d++) entry_q[d] <= '0;
    end else if (flush) begin
      for (int d = 0; d < DEPTH; d++) entry_q[d].valid <= 1'b0;
    end else begin
      if (pop) entry_q[head].valid <= 1'b0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        for (int d = 0; d < DEPTH; d++) begin
          if (hit[i][d]) begin
            entry_q[d].data  <= win_data[i];
            entry_q[d].flags <= win_flags[i];
          end
        end
        if (grant[i]) begin
          entry_q[tail + PTR_W'(rank[i])] <= BTBUpdateEntry'{
            valid: 1'b1, index: lane_idx[i], tag: lane_tag[i],
            data: win_data[i], flags: win_flags[i]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dropCount <= '0;
    else if (!flush) dropCount <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  btb_update_issuer_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .pop      (pop),
    .push_cnt (grant == '0 ? '0 : push_cnt),
    .head     (head),
    .tail     (tail),
    .occupancy(occupancy)
  );

endmodule

// File: tb/tb_btb_update_issuer.sv
// Directed table-driven bench for btb_update_issuer plus hand sequences for
// overflow, flush and asynchronous reset.
module tb_btb_update_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  brValid, brTaken, brIsAp;
  logic [31:0] brAddr [2];
  logic [31:0] brNextAddr [2];
  logic [2:0]  brFlags [2];
  logic        wrValid, wrReady;
  logic [8:0]  wrIndex;
  logic [6:0]  wrTag;
  logic [12:0] wrData;
  logic [2:0]  wrFlags;
  logic [15:0] dropCount;
  logic [3:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  btb_update_issuer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .brValid(brValid), .brTaken(brTaken), .brIsAp(brIsAp),
    .brAddr(brAddr), .brNextAddr(brNextAddr), .brFlags(brFlags),
    .wrValid(wrValid), .wrReady(wrReady), .wrIndex(wrIndex), .wrTag(wrTag),
    .wrData(wrData), .wrFlags(wrFlags), .dropCount(dropCount), .occupancy(occupancy)
  );

  typedef struct {
    logic [1:0]  v, t, ap;
    logic [31:0] a0, n0, a1, n1;
    logic [2:0]  f0, f1;
    logic        rdy;
    logic        e_vld;
    logic [8:0]  e_idx;
    logic [6:0]  e_tag;
    logic [12:0] e_dat;
    logic [2:0]  e_flg;
    logic [3:0]  e_occ;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] t, logic [1:0] ap,
                              logic [31:0] a0, logic [31:0] n0, logic [2:0] f0,
                              logic [31:0] a1, logic [31:0] n1, logic [2:0] f1,
                              logic rdy, logic ev, logic [8:0] ei, logic [6:0] et,
                              logic [12:0] ed, logic [2:0] ef, logic [3:0] eo);
    vec_t r;
    r.v = v; r.t = t; r.ap = ap;
    r.a0 = a0; r.n0 = n0; r.f0 = f0;
    r.a1 = a1; r.n1 = n1; r.f1 = f1;
    r.rdy = rdy; r.e_vld = ev; r.e_idx = ei; r.e_tag = et;
    r.e_dat = ed; r.e_flg = ef; r.e_occ = eo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] t, input logic [1:0] ap,
                       input logic [31:0] a0, input logic [31:0] n0, input logic [2:0] f0,
                       input logic [31:0] a1, input logic [31:0] n1, input logic [2:0] f1,
                       input logic rdy);
    brValid = v; brTaken = t; brIsAp = ap;
    brAddr[0] = a0; brNextAddr[0] = n0; brFlags[0] = f0;
    brAddr[1] = a1; brNextAddr[1] = n1; brFlags[1] = f1;
    wrReady = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 3'd0, rdy);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    idle(1'b0);

    // Expected state is what the outputs show after the edge that consumed the row.
    //            v     t     ap    a0        n0        f0    a1        n1        f1    rdy  vld idx     tag    dat       flg   occ
    tbl.push_back(mk(2'b00,2'b00,2'b00,32'h0,   32'h0,   3'd0,32'h0,   32'h0,   3'd0,1'b1,1'b0,9'h000,7'h00,13'h000, 3'd0, 4'd0));
    tbl.push_back(mk(2'b01,2'b01,2'b00,32'h1000,32'h2000,3'd4,32'h0,   32'h0,   3'd0,1'b1,1'b1,9'h000,7'h02,13'h800, 3'd4, 4'd1));
    tbl.push_back(mk(2'b00,2'b00,2'b00,32'h0,   32'h0,   3'd0,32'h0,   32'h0,   3'd0,1'b1,1'b0,9'h000,7'h00,13'h000, 3'd0, 4'd0));
    tbl.push_back(mk(2'b11,2'b11,2'b00,32'h1000,32'h2000,3'd4,32'h1004,32'h2400,3'd1,1'b0,1'b1,9'h000,7'h02,13'h800, 3'd4, 4'd2));
    tbl.push_back(mk(2'b01,2'b01,2'b01,32'h1008,32'h2800,3'd2,32'h0,   32'h0,   3'd0,1'b1,1'b1,9'h001,7'h02,13'h900, 3'd1, 4'd1));
    tbl.push_back(mk(2'b00,2'b00,2'b00,32'h0,   32'h0,   3'd0,32'h0,   32'h0,   3'd0,1'b1,1'b0,9'h000,7'h00,13'h000, 3'd0, 4'd0));
    tbl.push_back(mk(2'b11,2'b11,2'b00,32'h1000,32'h2000,3'd1,32'h1000,32'h3000,3'd2,1'b0,1'b1,9'h000,7'h02,13'hC00, 3'd2, 4'd1));
    tbl.push_back(mk(2'b01,2'b01,2'b00,32'h1000,32'h2400,3'd4,32'h0,   32'h0,   3'd0,1'b0,1'b1,9'h000,7'h02,13'h900, 3'd4, 4'd1));
    tbl.push_back(mk(2'b01,2'b01,2'b00,32'h1000,32'h2800,3'd3,32'h0,   32'h0,   3'd0,1'b1,1'b1,9'h000,7'h02,13'hA00, 3'd3, 4'd1));
    tbl.push_back(mk(2'b01,2'b00,2'b00,32'h1010,32'h2000,3'd4,32'h0,   32'h0,   3'd0,1'b1,1'b0,9'h000,7'h00,13'h000, 3'd0, 4'd0));
    tbl.push_back(mk(2'b00,2'b01,2'b00,32'h1014,32'h2000,3'd4,32'h0,   32'h0,   3'd0,1'b1,1'b0,9'h000,7'h00,13'h000, 3'd0, 4'd0));
    tbl.push_back(mk(2'b11,2'b11,2'b00,32'h1100,32'h5000,3'd0,32'h1104,32'h5400,3'd0,1'b0,1'b1,9'h040,7'h02,13'h1400,3'd0, 4'd2));
    tbl.push_back(mk(2'b10,2'b10,2'b00,32'h0,   32'h0,   3'd0,32'h1104,32'h6000,3'd6,1'b0,1'b1,9'h040,7'h02,13'h1400,3'd0, 4'd2));
    tbl.push_back(mk(2'b00,2'b00,2'b00,32'h0,   32'h0,   3'd0,32'h0,   32'h0,   3'd0,1'b1,1'b1,9'h041,7'h02,13'h1800,3'd6, 4'd1));
    tbl.push_back(mk(2'b00,2'b00,2'b00,32'h0,   32'h0,   3'd0,32'h0,   32'h0,   3'd0,1'b1,1'b0,9'h000,7'h00,13'h000, 3'd0, 4'd0));

    // Reset state.
    #12;
    chk("rst_wrValid", 32'(wrValid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_dropCount", 32'(dropCount), 32'd0);
    chk("rst_wrFields", {wrIndex, wrTag, wrData, wrFlags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].t, tbl[k].ap, tbl[k].a0, tbl[k].n0, tbl[k].f0,
            tbl[k].a1, tbl[k].n1, tbl[k].f1, tbl[k].rdy);
      step();
      chk($sformatf("vec%0d_wrValid", k), 32'(wrValid), 32'(tbl[k].e_vld));
      chk($sformatf("vec%0d_wrIndex", k), 32'(wrIndex), 32'(tbl[k].e_idx));
      chk($sformatf("vec%0d_wrTag", k), 32'(wrTag), 32'(tbl[k].e_tag));
      chk($sformatf("vec%0d_wrData", k), 32'(wrData), 32'(tbl[k].e_dat));
      chk($sformatf("vec%0d_wrFlags", k), 32'(wrFlags), 32'(tbl[k].e_flg));
      chk($sformatf("vec%0d_occupancy", k), 32'(occupancy), 32'(tbl[k].e_occ));
      chk($sformatf("vec%0d_dropCount", k), 32'(dropCount), 32'd0);
    end

    // Overflow: 10 distinct branches with the port stalled; 8 kept, 2 dropped.
    for (int c = 0; c < 5; c++) begin
      drive(2'b11, 2'b11, 2'b00,
            32'h2000 + 32'(8*c),     32'h4000 + 32'(8*c),     3'd0,
            32'h2000 + 32'(8*c + 4), 32'h4000 + 32'(8*c + 4), 3'd0, 1'b0);
      step();
    end
    idle(1'b0);
    chk("ovf_occupancy", 32'(occupancy), 32'd8);
    chk("ovf_dropCount", 32'(dropCount), 32'd2);
    step();
    chk("ovf_hold_data", 32'(wrData), 32'h1000);
    idle(1'b1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_wrValid", k), 32'(wrValid), 32'd1);
      chk($sformatf("drain%0d_wrData", k), 32'(wrData), 32'h1000 + 32'(k));
      step();
    end
    chk("drain_empty_wrValid", 32'(wrValid), 32'd0);
    chk("drain_empty_occupancy", 32'(occupancy), 32'd0);

    // Flush with a same-cycle taken branch.
    drive(2'b11, 2'b11, 2'b00, 32'h3000, 32'h5000, 3'd0, 32'h3004, 32'h5004, 3'd0, 1'b0);
    step();
    drive(2'b01, 2'b01, 2'b00, 32'h3008, 32'h5008, 3'd0, 32'h0, 32'h0, 3'd0, 1'b0);
    step();
    chk("preflush_occupancy", 32'(occupancy), 32'd3);
    drive(2'b01, 2'b01, 2'b00, 32'h300C, 32'h500C, 3'd0, 32'h0, 32'h0, 3'd0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(1'b1);
    chk("flush_wrValid", 32'(wrValid), 32'd0);
    chk("flush_occupancy", 32'(occupancy), 32'd0);
    chk("flush_dropCount", 32'(dropCount), 32'd2);

    // Asynchronous reset while holding 5 entries.
    drive(2'b11, 2'b11, 2'b00, 32'h4000, 32'h6000, 3'd0, 32'h4004, 32'h6004, 3'd0, 1'b0);
    step();
    drive(2'b11, 2'b11, 2'b00, 32'h4008, 32'h6008, 3'd0, 32'h400C, 32'h600C, 3'd0, 1'b0);
    step();
    drive(2'b01, 2'b01, 2'b00, 32'h4010, 32'h6010, 3'd0, 32'h0, 32'h0, 3'd0, 1'b0);
    step();
    idle(1'b1);
    chk("prerst_occupancy", 32'(occupancy), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wrValid", 32'(wrValid), 32'd0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_dropCount", 32'(dropCount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 2'b01, 2'b00, 32'h1000, 32'h2000, 3'd1, 32'h0, 32'h0, 3'd0, 1'b1);
    step();
    idle(1'b1);
    chk("postrst_wrValid", 32'(wrValid), 32'd1);
    chk("postrst_wrData", 32'(wrData), 32'h800);
    step();
    chk("postrst_occupancy", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
